neuron_controller: RTL

- Sequencing FSM that drives one neuron datapath.
- Generates the accumulator clear, load and input-select offset, and the activation ready strobe.
- Captures the datapath's activated result and presents it downstream on a valid/ack handshake.
- Sits between the layer scheduler (start) and the next layer / output buffer (out_valid/out_ack).

---
 rtl/neuron_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/neuron_controller.sv
// neuron_controller: Moore sequencing FSM for one neuron datapath.
// Generates accumulator clear/load, input-select offset and the activation
// ready strobe, then holds the activated result on a valid/ack handshake.
// Optional feature macro: NEURON_CTRL_BIAS_CYCLE_EN adds a one-cycle BIAS
// load (bias_sel) between the accumulation and activation phases.
module neuron_controller #(
    parameter int N  = 10,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DW-1:0]        result_in,
    output logic [$clog2(N)-1:0] offset,
    output logic                 clr,
    output logic                 ld,
    output logic                 ready,
    output logic                 busy,
    output logic                 out_valid,
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
    output logic                 bias_sel,
`endif
    output logic [DW-1:0]        result_out,
    input  logic                 out_ack
);

    localparam int OW = $clog2(N);
    localparam logic [OW-1:0] LAST = OW'(N - 1);
    localparam logic [OW-1:0] ONE  = OW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
        S_BIAS,
`endif
        S_ACT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic            clr_q, clr_d;
    logic            ld_q, ld_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   result_q, result_d;
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
    logic            bias_q, bias_d;
`endif

    // Next-state logic; every output is computed for the state being entered
    // so that the registered outputs are a pure function of the current state.
    always_comb begin
        state_d     = state_q;
        offset_d    = '0;
        clr_d       = 1'b0;
        ld_d        = 1'b0;
        ready_d     = 1'b0;
        out_valid_d = 1'b0;
        result_d    = result_q;
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
        bias_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    clr_d   = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_ACCUM;
                ld_d    = 1'b1;
            end
            S_ACCUM: begin
                if (offset_q == LAST) begin
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
                    state_d = S_BIAS;
                    ld_d    = 1'b1;
                    bias_d  = 1'b1;
`else
                    state_d = S_ACT;
                    ready_d = 1'b1;
`endif
                end else begin
                    offset_d = offset_q + ONE;
                    ld_d     = 1'b1;
                end
            end
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
            S_BIAS: begin
                state_d = S_ACT;
                ready_d = 1'b1;
            end
`endif
            S_ACT: begin
                state_d     = S_DONE;
                out_valid_d = 1'b1;
                result_d    = result_in;
            end
            S_DONE: begin
                if (out_ack) begin
                    if (start) begin
                        state_d = S_CLEAR;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any evaluation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            clr_q       <= 1'b0;
            ld_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
            bias_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            clr_q       <= clr_d;
            ld_q        <= ld_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
            bias_q      <= bias_d;
`endif
        end
    end

    assign offset     = offset_q;
    assign clr        = clr_q;
    assign ld         = ld_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign result_out = result_q;
`ifdef NEURON_CTRL_BIAS_CYCLE_EN
    assign bias_sel   = bias_q;
`endif

endmodule
